// File: rtl/rs_pkg.sv
// Shared types for the reservation station: op codes, entry states and
// the tag / destination widths used across the slice.
package rs_pkg;

    localparam int RS_TAG_W  = 5;
    localparam int RS_DEST_W = 5;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLT = 3'd5
    } rs_op_e;

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2,
        ST_EXEC  = 2'd3
    } rs_state_e;

endpackage

// File: rtl/rs_alu_pipe.sv
// Functional unit: combinational ALU at the input followed by LAT register
// stages; the whole pipe freezes while stall_i is high.
module rs_alu_pipe
    import rs_pkg::*;
#(
    parameter int LAT   = 3,
    parameter int XLEN  = 32,
    parameter int TAG_W = RS_TAG_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 stall_i,
    input  logic                 in_valid_i,
    input  logic [2:0]           in_op_i,
    input  logic [XLEN-1:0]      in_a_i,
    input  logic [XLEN-1:0]      in_b_i,
    input  logic [TAG_W-1:0]     in_tag_i,
    input  logic [RS_DEST_W-1:0] in_dest_i,
    output logic                 out_valid_o,
    output logic [TAG_W-1:0]     out_tag_o,
    output logic [RS_DEST_W-1:0] out_dest_o,
    output logic [XLEN-1:0]      out_data_o
);

    logic [XLEN-1:0] alu_res;

    always_comb begin
        alu_res = '0;
        case (rs_op_e'(in_op_i))
            OP_ADD:  alu_res = in_a_i + in_b_i;
            OP_SUB:  alu_res = in_a_i - in_b_i;
            OP_AND:  alu_res = in_a_i & in_b_i;
            OP_OR:   alu_res = in_a_i | in_b_i;
            OP_XOR:  alu_res = in_a_i ^ in_b_i;
            OP_SLT:  alu_res = XLEN'($signed(in_a_i) < $signed(in_b_i));
            default: alu_res = '0;
        endcase
    end

    logic                 vld_q  [LAT];
    logic [XLEN-1:0]      data_q [LAT];
    logic [TAG_W-1:0]     tag_q  [LAT];
    logic [RS_DEST_W-1:0] dest_q [LAT];

    // Stage 0 latches the ALU result; later stages only carry it along.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < LAT; k++) begin
                vld_q[k]  <= 1'b0;
                data_q[k] <= '0;
                tag_q[k]  <= '0;
                dest_q[k] <= '0;
            end
        end else if (flush_i) begin
            for (int k = 0; k < LAT; k++) begin
                vld_q[k] <= 1'b0;
            end
        end else if (!stall_i) begin
            vld_q[0]  <= in_valid_i;
            data_q[0] <= alu_res;
            tag_q[0]  <= in_tag_i;
            dest_q[0] <= in_dest_i;
            for (int k = 1; k < LAT; k++) begin
                vld_q[k]  <= vld_q[k-1];
                data_q[k] <= data_q[k-1];
                tag_q[k]  <= tag_q[k-1];
                dest_q[k] <= dest_q[k-1];
            end
        end
    end

    assign out_valid_o = vld_q[LAT-1];
    assign out_data_o  = data_q[LAT-1];
    assign out_tag_o   = tag_q[LAT-1];
    assign out_dest_o  = dest_q[LAT-1];

endmodule

// File: rtl/reservation_station.sv
// Reservation station: DEPTH entries that capture operands off the CDB,
// issue the lowest ready entry into rs_alu_pipe and free it on result accept.
module reservation_station
    import rs_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int XLEN     = 32,
    parameter int TAG_W    = RS_TAG_W,
    parameter int TAG_BASE = 8,
    parameter int LAT      = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 disp_valid_i,
    output logic                 disp_ready_o,
    input  logic [2:0]           disp_op_i,
    input  logic [RS_DEST_W-1:0] disp_dest_i,
    input  logic                 disp_rdy1_i,
    input  logic                 disp_rdy2_i,
    input  logic [TAG_W-1:0]     disp_tag1_i,
    input  logic [TAG_W-1:0]     disp_tag2_i,
    input  logic [XLEN-1:0]      disp_val1_i,
    input  logic [XLEN-1:0]      disp_val2_i,
    output logic [TAG_W-1:0]     disp_tag_o,
    input  logic                 cdb_valid_i,
    input  logic [TAG_W-1:0]     cdb_tag_i,
    input  logic [XLEN-1:0]      cdb_data_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [TAG_W-1:0]     res_tag_o,
    output logic [RS_DEST_W-1:0] res_dest_o,
    output logic [XLEN-1:0]      res_data_o,
    output logic                 full_o
);

    localparam int IDX_W = $clog2(DEPTH);

    if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
        $error("reservation_station: DEPTH must lie in 2..16");
    end
    if (LAT < 1 || LAT > 8) begin : g_bad_lat
        $error("reservation_station: LAT must lie in 1..8");
    end
    if (TAG_BASE + DEPTH > 2**TAG_W) begin : g_bad_tag
        $error("reservation_station: TAG_BASE+DEPTH exceeds the tag space");
    end

    rs_state_e            state_q [DEPTH];
    rs_state_e            state_d [DEPTH];
    rs_op_e               op_q    [DEPTH];
    rs_op_e               op_d    [DEPTH];
    logic [RS_DEST_W-1:0] dest_q  [DEPTH];
    logic [RS_DEST_W-1:0] dest_d  [DEPTH];
    logic                 rdy1_q  [DEPTH];
    logic                 rdy1_d  [DEPTH];
    logic                 rdy2_q  [DEPTH];
    logic                 rdy2_d  [DEPTH];
    logic [TAG_W-1:0]     tag1_q  [DEPTH];
    logic [TAG_W-1:0]     tag1_d  [DEPTH];
    logic [TAG_W-1:0]     tag2_q  [DEPTH];
    logic [TAG_W-1:0]     tag2_d  [DEPTH];
    logic [XLEN-1:0]      val1_q  [DEPTH];
    logic [XLEN-1:0]      val1_d  [DEPTH];
    logic [XLEN-1:0]      val2_q  [DEPTH];
    logic [XLEN-1:0]      val2_d  [DEPTH];

    logic [DEPTH-1:0] hit1;
    logic [DEPTH-1:0] hit2;

    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_snoop
        assign hit1[gi] = cdb_valid_i && (state_q[gi] == ST_WAIT) && !rdy1_q[gi] && (tag1_q[gi] == cdb_tag_i);
        assign hit2[gi] = cdb_valid_i && (state_q[gi] == ST_WAIT) && !rdy2_q[gi] && (tag2_q[gi] == cdb_tag_i);
    end

    logic             free_found;
    logic             ready_found;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] ready_idx;

    // Descending scan so the lowest matching index wins.
    always_comb begin
        free_found  = 1'b0;
        ready_found = 1'b0;
        free_idx    = '0;
        ready_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (state_q[i] == ST_FREE) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (state_q[i] == ST_READY) begin
                ready_found = 1'b1;
                ready_idx   = IDX_W'(i);
            end
        end
    end

    logic             stall;
    logic             issue_en;
    logic             disp_fire;
    logic             handshake;
    logic [TAG_W-1:0] ret_off;
    logic [IDX_W-1:0] ret_idx;
    logic             byp_rdy1;
    logic             byp_rdy2;
    logic [XLEN-1:0]  byp_val1;
    logic [XLEN-1:0]  byp_val2;

    assign full_o       = !free_found;
    assign disp_ready_o = free_found;
    assign disp_tag_o   = TAG_W'(TAG_BASE) + TAG_W'(free_idx);

    assign stall     = res_valid_o && !res_ready_i;
    assign issue_en  = ready_found && !stall && !flush_i;
    assign disp_fire = disp_valid_i && free_found && !flush_i;
    assign handshake = res_valid_o && res_ready_i && !flush_i;
    assign ret_off   = res_tag_o - TAG_W'(TAG_BASE);
    assign ret_idx   = ret_off[IDX_W-1:0];

    // An operand broadcast in the dispatch cycle is picked up directly.
    assign byp_rdy1 = disp_rdy1_i || (cdb_valid_i && (disp_tag1_i == cdb_tag_i));
    assign byp_rdy2 = disp_rdy2_i || (cdb_valid_i && (disp_tag2_i == cdb_tag_i));
    assign byp_val1 = disp_rdy1_i ? disp_val1_i : cdb_data_i;
    assign byp_val2 = disp_rdy2_i ? disp_val2_i : cdb_data_i;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            state_d[i] = state_q[i];
            op_d[i]    = op_q[i];
            dest_d[i]  = dest_q[i];
            rdy1_d[i]  = rdy1_q[i];
            rdy2_d[i]  = rdy2_q[i];
            tag1_d[i]  = tag1_q[i];
            tag2_d[i]  = tag2_q[i];
            val1_d[i]  = val1_q[i];
            val2_d[i]  = val2_q[i];
            if (hit1[i]) begin
                rdy1_d[i] = 1'b1;
                val1_d[i] = cdb_data_i;
            end
            if (hit2[i]) begin
                rdy2_d[i] = 1'b1;
                val2_d[i] = cdb_data_i;
            end
            if (state_q[i] == ST_WAIT && rdy1_d[i] && rdy2_d[i]) begin
                state_d[i] = ST_READY;
            end
            if (issue_en && ready_idx == IDX_W'(i)) begin
                state_d[i] = ST_EXEC;
            end
            if (handshake && ret_idx == IDX_W'(i)) begin
                state_d[i] = ST_FREE;
            end
            if (disp_fire && free_idx == IDX_W'(i)) begin
                state_d[i] = (byp_rdy1 && byp_rdy2) ? ST_READY : ST_WAIT;
                op_d[i]    = rs_op_e'(disp_op_i);
                dest_d[i]  = disp_dest_i;
                rdy1_d[i]  = byp_rdy1;
                rdy2_d[i]  = byp_rdy2;
                tag1_d[i]  = disp_tag1_i;
                tag2_d[i]  = disp_tag2_i;
                val1_d[i]  = byp_val1;
                val2_d[i]  = byp_val2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= ST_FREE;
                op_q[i]    <= OP_ADD;
                dest_q[i]  <= '0;
                rdy1_q[i]  <= 1'b0;
                rdy2_q[i]  <= 1'b0;
                tag1_q[i]  <= '0;
                tag2_q[i]  <= '0;
                val1_q[i]  <= '0;
                val2_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= flush_i ? ST_FREE : state_d[i];
                op_q[i]    <= op_d[i];
                dest_q[i]  <= dest_d[i];
                rdy1_q[i]  <= rdy1_d[i];
                rdy2_q[i]  <= rdy2_d[i];
                tag1_q[i]  <= tag1_d[i];
                tag2_q[i]  <= tag2_d[i];
                val1_q[i]  <= val1_d[i];
                val2_q[i]  <= val2_d[i];
            end
        end
    end

    rs_alu_pipe #(
        .LAT   (LAT),
        .XLEN  (XLEN),
        .TAG_W (TAG_W)
    ) u_pipe (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .stall_i     (stall),
        .in_valid_i  (issue_en),
        .in_op_i     (op_q[ready_idx]),
        .in_a_i      (val1_q[ready_idx]),
        .in_b_i      (val2_q[ready_idx]),
        .in_tag_i    (TAG_W'(TAG_BASE) + TAG_W'(ready_idx)),
        .in_dest_i   (dest_q[ready_idx]),
        .out_valid_o (res_valid_o),
        .out_tag_o   (res_tag_o),
        .out_dest_o  (res_dest_o),
        .out_data_o  (res_data_o)
    );

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: results are checked against a
// scoreboard filled at dispatch time and drained by a result monitor.
module tb_reservation_station;
    import rs_pkg::*;

    localparam int LAT   = 3;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    logic [2:0]  disp_op;
    logic [4:0]  disp_dest;
    logic        disp_rdy1;
    logic        disp_rdy2;
    logic [4:0]  disp_tag1;
    logic [4:0]  disp_tag2;
    logic [31:0] disp_val1;
    logic [31:0] disp_val2;
    logic [4:0]  disp_tag;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        res_valid;
    logic        res_ready;
    logic [4:0]  res_tag;
    logic [4:0]  res_dest;
    logic [31:0] res_data;
    logic        full;

    always #5 clk = ~clk;

    reservation_station #(
        .DEPTH    (DEPTH),
        .XLEN     (32),
        .TAG_W    (5),
        .TAG_BASE (8),
        .LAT      (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush),
        .disp_valid_i (disp_valid),
        .disp_ready_o (disp_ready),
        .disp_op_i    (disp_op),
        .disp_dest_i  (disp_dest),
        .disp_rdy1_i  (disp_rdy1),
        .disp_rdy2_i  (disp_rdy2),
        .disp_tag1_i  (disp_tag1),
        .disp_tag2_i  (disp_tag2),
        .disp_val1_i  (disp_val1),
        .disp_val2_i  (disp_val2),
        .disp_tag_o   (disp_tag),
        .cdb_valid_i  (cdb_valid),
        .cdb_tag_i    (cdb_tag),
        .cdb_data_i   (cdb_data),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .res_tag_o    (res_tag),
        .res_dest_o   (res_dest),
        .res_data_o   (res_data),
        .full_o       (full)
    );

    typedef struct {
        logic [4:0]  tag;
        logic [4:0]  dest;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input rs_op_e op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int tag, input int dest, input logic [31:0] data);
        exp_t e;
        e.tag  = 5'(tag);
        e.dest = 5'(dest);
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic dispatch(input rs_op_e op, input int dest,
                            input bit r1, input int t1, input logic [31:0] v1,
                            input bit r2, input int t2, input logic [31:0] v2,
                            input int exp_tag);
        check("disp_ready", 32'(disp_ready), 32'd1);
        check("disp_tag", 32'(disp_tag), 32'(exp_tag));
        disp_valid = 1'b1;
        disp_op    = op;
        disp_dest  = 5'(dest);
        disp_rdy1  = r1;
        disp_tag1  = 5'(t1);
        disp_val1  = v1;
        disp_rdy2  = r2;
        disp_tag2  = 5'(t2);
        disp_val2  = v2;
        $display("dispatch op=%0d dest=%0d tag=%0d", op, dest, exp_tag);
        step();
        disp_valid = 1'b0;
    endtask

    task automatic cdb(input int tag, input logic [31:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = 5'(tag);
        cdb_data  = data;
        $display("cdb tag=%0d data=0x%0h", tag, data);
        step();
        cdb_valid = 1'b0;
    endtask

    task automatic wait_res(output int n);
        n = 0;
        while (!res_valid && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic idle_watch(input int cycles, output bit seen);
        seen = res_valid;
        for (int k = 0; k < cycles; k++) begin
            step();
            if (res_valid) seen = 1'b1;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            step();
            n++;
        end
        check(name, 32'(sb.size()), 32'd0);
        step();
    endtask

    // Each accepted result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && !flush && res_valid && res_ready) begin
            check("res_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                $display("result tag=%0d dest=%0d data=0x%0h", res_tag, res_dest, res_data);
                check("res_tag", 32'(res_tag), 32'(mon_e.tag));
                check("res_dest", 32'(res_dest), 32'(mon_e.dest));
                check("res_data", res_data, mon_e.data);
            end
        end
    end

    initial begin
        int n;
        bit seen;
        rst = 1'b0; flush = 1'b0; disp_valid = 1'b0; disp_op = 3'd0; disp_dest = 5'd0;
        disp_rdy1 = 1'b0; disp_rdy2 = 1'b0; disp_tag1 = 5'd0; disp_tag2 = 5'd0;
        disp_val1 = 32'd0; disp_val2 = 32'd0; cdb_valid = 1'b0; cdb_tag = 5'd0;
        cdb_data = 32'd0; res_ready = 1'b1;

        // Reset state
        repeat (2) step();
        rst = 1'b1;
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_tag", 32'(res_tag), 32'd0);
        check("rst_res_dest", 32'(res_dest), 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_disp_ready", 32'(disp_ready), 32'd1);

        // ADD 5+7, both ready
        push(8, 1, model(OP_ADD, 32'd5, 32'd7));
        dispatch(OP_ADD, 1, 1, 0, 32'd5, 1, 0, 32'd7, 8);
        wait_res(n);
        check("add_latency", 32'(n), 32'(LAT));
        drain("add_drain");

        // Operand 1 waits on tag 3
        push(8, 2, 32'h30);
        dispatch(OP_ADD, 2, 0, 3, 32'd0, 1, 0, 32'h20, 8);
        idle_watch(5, seen);
        check("wait_no_issue", 32'(seen), 32'd0);
        cdb(3, 32'h10);
        wait_res(n);
        check("wait_latency", 32'(n), 32'(LAT));
        drain("wait_drain");

        // Dispatch-cycle bypass
        push(8, 3, model(OP_SUB, 32'd9, 32'd4));
        cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_data = 32'd9;
        dispatch(OP_SUB, 3, 0, 3, 32'd0, 1, 0, 32'd4, 8);
        cdb_valid = 1'b0;
        wait_res(n);
        check("bypass_latency", 32'(n), 32'(LAT));
        drain("bypass_drain");

        // Fill the station behind an out-of-range producer tag
        for (int i = 0; i < DEPTH; i++) begin
            push(8 + i, i, 32'h100 + 32'(i));
            dispatch(OP_ADD, i, 0, 20, 32'd0, 1, 0, 32'(i), 8 + i);
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_disp_ready", 32'(disp_ready), 32'd0);
        disp_valid = 1'b1; disp_dest = 5'd30; disp_rdy1 = 1'b1; disp_rdy2 = 1'b1;
        step();
        disp_valid = 1'b0;
        check("ninth_full", 32'(full), 32'd1);
        cdb(20, 32'h100);
        drain("fill_drain");
        check("fill_empty_full", 32'(full), 32'd0);
        check("fill_empty_tag", 32'(disp_tag), 32'd8);

        // Back-pressure on the result port
        res_ready = 1'b0;
        push(8, 4, model(OP_XOR, 32'h0000F0F0, 32'h00000FF0));
        dispatch(OP_XOR, 4, 1, 0, 32'h0000F0F0, 1, 0, 32'h00000FF0, 8);
        push(9, 5, model(OP_OR, 32'd1, 32'd2));
        dispatch(OP_OR, 5, 1, 0, 32'd1, 1, 0, 32'd2, 9);
        push(10, 6, model(OP_SLT, 32'hFFFFFFFB, 32'd3));
        dispatch(OP_SLT, 6, 1, 0, 32'hFFFFFFFB, 1, 0, 32'd3, 10);
        push(11, 7, model(OP_SUB, 32'd0, 32'd1));
        dispatch(OP_SUB, 7, 1, 0, 32'd0, 1, 0, 32'd1, 11);
        wait_res(n);
        check("stall_valid", 32'(res_valid), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            check("stall_hold_valid", 32'(res_valid), 32'd1);
            check("stall_hold_tag", 32'(res_tag), 32'd8);
            check("stall_hold_data", res_data, 32'h0000FF00);
        end
        res_ready = 1'b1;
        drain("stall_drain");

        // Flush with entries in EXEC and WAIT
        res_ready = 1'b0;
        dispatch(OP_ADD, 7, 1, 0, 32'd1, 1, 0, 32'd1, 8);
        dispatch(OP_ADD, 8, 0, 25, 32'd0, 1, 0, 32'd1, 9);
        dispatch(OP_ADD, 9, 0, 26, 32'd0, 1, 0, 32'd1, 10);
        wait_res(n);
        check("pre_flush_valid", 32'(res_valid), 32'd1);
        flush = 1'b1;
        disp_valid = 1'b1; disp_rdy1 = 1'b1; disp_rdy2 = 1'b1;
        step();
        flush = 1'b0;
        disp_valid = 1'b0;
        check("flush_res_valid", 32'(res_valid), 32'd0);
        check("flush_full", 32'(full), 32'd0);
        check("flush_disp_tag", 32'(disp_tag), 32'd8);
        res_ready = 1'b1;
        cdb(25, 32'd1);
        cdb(26, 32'd2);
        idle_watch(10, seen);
        check("flush_no_result", 32'(seen), 32'd0);

        // Reset in the middle of execution
        dispatch(OP_ADD, 1, 1, 0, 32'd3, 1, 0, 32'd4, 8);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("midrst_res_valid", 32'(res_valid), 32'd0);
        check("midrst_res_tag", 32'(res_tag), 32'd0);
        check("midrst_res_data", res_data, 32'd0);
        idle_watch(10, seen);
        check("midrst_no_result", 32'(seen), 32'd0);
        check("midrst_full", 32'(full), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameter DEPTH, default 8: number of station entries, 2..16.
REQ-002 Parameter XLEN, default 32: operand and result width.
REQ-003 Parameter TAG_W, default 5: producer tag width.
REQ-004 Parameter TAG_BASE, default 8: tag of entry i is TAG_BASE+i; TAG_BASE+DEPTH <= 2**TAG_W, elaboration error otherwise.
REQ-005 Parameter LAT, default 3: functional-unit pipeline latency in cycles, 1..8.
REQ-006 Reset rst, synchronous, active-low; clock clk.
REQ-007 clk  in  1  clock, all state on rising edge.
REQ-008 rst  in  1  synchronous active-low reset.
REQ-009 flush  in  1  discard all entries and in-flight results.
REQ-010 disp_valid / disp_ready  in / out  1 / 1  dispatch handshake; transfer when both high.
REQ-011 disp_op  in  3  operation code from shared package.
REQ-012 disp_dest  in  5  architectural destination register id.
REQ-013 disp_rdy1, disp_rdy2  in  1 each  operand value valid; else wait on tag.
REQ-014 disp_tag1, disp_tag2  in  TAG_W each  producer tag when not ready.
REQ-015 disp_val1, disp_val2  in  XLEN each  operand value when ready.
REQ-016 disp_tag  out  TAG_W  tag allocated to the dispatching instruction (valid when disp_valid and disp_ready).
REQ-017 cdb_valid, cdb_tag, cdb_data  in  1, TAG_W, XLEN  common data bus snoop.
REQ-018 res_valid / res_ready  out / in  1 / 1  result handshake towards CDB arbiter.
REQ-019 res_tag, res_dest, res_data  out  TAG_W, 5, XLEN  result tag, destination id, value.
REQ-020 full  out  1  no FREE entry.

Function
REQ-021 Each entry SHALL have states FREE, WAIT (an operand pending), READY (both valid), EXEC (issued, result not yet accepted).
REQ-022 Dispatch SHALL allocate the lowest-index FREE entry; disp_tag = TAG_BASE+index; disp_ready = !full, combinational from current state.
REQ-023 disp_valid while disp_ready=0 SHALL be ignored, no state change.
REQ-024 Allocated entry SHALL go to READY if both operands valid after capture, else WAIT.
REQ-025 Every cycle with cdb_valid, each WAIT operand whose tag equals cdb_tag SHALL capture cdb_data; both operands of one entry may capture in the same cycle.
REQ-026 Dispatch-cycle bypass: a dispatching operand with rdy=0 and tag equal to cdb_tag while cdb_valid SHALL capture cdb_data at allocation.
REQ-027 Issue: at most one entry per cycle, lowest-index READY entry, only when the pipeline is not stalled; entry moves to EXEC.
REQ-028 Entry captured to READY in cycle N SHALL be issuable no earlier than cycle N+1.
REQ-029 Result SHALL present res_valid exactly LAT cycles after issue when no stall occurs.
REQ-030 res_valid && !res_ready SHALL stall the whole pipeline and block issue; outputs held stable until accepted.
REQ-031 On result handshake the owning entry SHALL return to FREE in the same edge; it is allocatable from the next cycle.
REQ-032 Ops: ADD, SUB, AND, OR, XOR, SLT (signed, result 0/1); ADD/SUB wrap modulo 2**XLEN.
REQ-033 flush SHALL set all entries FREE, invalidate pipeline, res_valid=0 next cycle; flush overrides same-cycle dispatch, issue and handshake.
REQ-034 cdb tags outside TAG_BASE..TAG_BASE+DEPTH-1 SHALL still be snooped (other stations' producers).

Reset
REQ-035 rst=0 at a rising edge SHALL set all entries FREE, clear pipeline valids, res_valid=0, res_tag/res_dest/res_data=0; disp_ready=1 and full=0 in the first cycle after reset.
REQ-036 Reset mid-operation SHALL discard all state without emitting a result.

Structure
REQ-037 Shared package rs_pkg SHALL hold the op enum, entry-state enum and tag width constant.
REQ-038 Pipeline and ALU SHALL be a sub-module rs_alu_pipe (LAT, XLEN parameters, valid/stall in, tag/dest carried alongside).
REQ-039 Station logic (entries, snoop, allocation, issue select) SHALL reside in reservation_station.

Verification
REQ-040 Dispatch ADD 5+7 both ready, res_ready=1 -> res_valid 1+LAT cycles later, res_data=12, res_tag=8.
REQ-041 Dispatch op1 waiting on tag 3, then cdb(tag 3, 0x10); op2=0x20 -> result 0x30 LAT cycles after issue; no issue before cdb.
REQ-042 Dispatch with tag 3 pending while cdb(tag 3, 9) in same cycle -> entry READY, SUB 9-4 yields 5.
REQ-043 Fill 8 entries waiting on tag 20 -> full=1, disp_ready=0; ninth dispatch ignored; cdb tag 20 -> issue order tags 8..15.
REQ-044 Hold res_ready=0 for 4 cycles with result pending -> outputs stable, no new issue; release -> results in order without loss.
REQ-045 flush with 3 entries EXEC/WAIT -> next cycle res_valid=0, full=0, later cdb matches cause no result.
